decl_checker: RTL and testbench
===============================

// Module: decl_checker
// PURPOSE
//  Byte-serial syntax checker for C declaration statements: <type> <id>{,<id>};
//  with type in {int, char}. Next generation of the single-keyword int checker:
//  adds input valid qualifier, a second type keyword, a bounded identifier length,
//  per-statement done/ok results, id counts, and saturating ok/error statistics.
// PARAMETERS
//  MAX_ID_LEN  8  longest legal identifier, chars; MAX_ID_LEN >= 4
//  ID_CNT_W    4  width of id_num; count saturates at 2^ID_CNT_W-1
//  CNT_W       16 width of ok_cnt / err_cnt; both saturate at all-ones
// PORTS
//  clk      in   1         single clock, posedge
//  reset    in   1         synchronous, active-high; wins over every other input
//  in       in   8         ASCII byte
//  in_valid in   1         in is consumed only on cycles where in_valid=1
//  done     out  1         1-cycle pulse: a statement was closed by ';'
//  out      out  1         result of last closed statement (1=legal); holds between done
//  id_num   out  ID_CNT_W  identifiers declared in last closed statement
//  ok_cnt   out  CNT_W     legal statements since reset
//  err_cnt  out  CNT_W     illegal statements since reset
// BEHAVIOUR
//  - Reset: state=IDLE, done=0, out=0, id_num=0, ok_cnt=0, err_cnt=0, err flag cleared.
//  - in_valid=0: no state/flag/counter change; done=0 that cycle.
//  - Whitespace (WS) = ' ' or '\t'. Letter = A-Z, a-z, '_'. Digit = 0-9.
//  - States: IDLE, KW (matching "int"/"char", per-char position counter), KW_WS,
//    ID_START, ID, ID_WS, ERR. Optional IDX_START, IDX, IDX_END (see CONFIGURATION).
//  - IDLE: WS or ';' -> stay, no done (empty statement ignored); 'i'/'c' -> KW;
//    anything else -> ERR.
//  - KW: next char must extend "int" or "char"; mismatch -> ERR; keyword complete -> KW_WS.
//  - KW_WS: first char must be WS (else ERR); extra WS stays; Letter -> ID.
//  - ID_START (after ','): WS stays; Letter -> ID; else ERR.
//  - ID: Letter/Digit extends, length counter +1; WS -> ID_WS; ',' -> ID_START;
//    ';' -> close. Other bytes -> ERR.
//  - ID_WS: WS stays; ',' -> ID_START; ';' -> close; else ERR.
//  - Identifier termination (WS, ',' or ';' leaving ID): error if length > MAX_ID_LEN
//    or text equals "int" or "char"; otherwise id count +1 (saturating).
//    Error here sets err flag but state moves on as for a legal id (scan continues).
//  - ';' in ERR, or a ';' close: go IDLE; next cycle done=1, out=~err,
//    id_num=count (0 when err), ok_cnt or err_cnt +1 (saturating); err/count cleared.
//  - ';' seen in KW, KW_WS or ID_START: illegal statement, closes with out=0.
//  - Latency: done asserts exactly 1 cycle after the accepted ';'. Back-to-back
//    statements at full rate: done may assert on consecutive accepted ';' bytes.
//  - Reset mid-statement: partial statement dropped, no done, no counter update.
//  - Every non-ERR state: a byte outside the listed classes -> ERR.
// CONFIGURATION
//  ARRAY_DECL_EN defined: an identifier may take one suffix '[' Digit+ ']':
//   ID '[' -> IDX_START; Digit -> IDX; IDX Digit stays; ']' -> IDX_END;
//   IDX_END: WS -> ID_WS, ',' -> ID_START, ';' -> close; '[]', non-digit index,
//   second '[' -> ERR. Identifier checks apply to the name before '['.
//  ARRAY_DECL_EN undefined: '[' is an illegal byte in ID (-> ERR); IDX states absent.
// TESTING
//  "int a,b;" -> 1 cycle after ';': done=1, out=1, id_num=2, ok_cnt=1, err_cnt=0.
//  "char  x1 , _y ;" -> out=1, id_num=2; then "int int;" -> out=0, id_num=0, err_cnt=1.
//  "int 1a;" and "intx;" -> both out=0; "  ;;" -> no done, counters unchanged.
//  MAX_ID_LEN=8: "int abcdefgh;" -> out=1; "int abcdefghi;" -> out=0.
//  CNT_W=2: 5 legal statements -> ok_cnt=3; in_valid=0 gaps mid-statement change nothing;
//   reset after "int a" then ";" -> no done, counters 0.
//  ARRAY_DECL_EN: "int a[10],b;" -> out=1, id_num=2; "int a[];" -> out=0;
//   without macro "int a[10];" -> out=0.

Source files
------------

// File: rtl/decl_checker.sv
// Byte-serial syntax checker for "<int|char> <id>{,<id>};" declaration statements.
// Define ARRAY_DECL_EN to accept one "[digits]" suffix per identifier.
module decl_checker #(
    parameter int unsigned MAX_ID_LEN = 8,
    parameter int unsigned ID_CNT_W   = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in,
    input  logic                in_valid,
    output logic                done,
    output logic                out,
    output logic [ID_CNT_W-1:0] id_num,
    output logic [CNT_W-1:0]    ok_cnt,
    output logic [CNT_W-1:0]    err_cnt
);
    // Identifier length saturates one past the legal maximum.
    localparam int unsigned      LEN_W   = $clog2(MAX_ID_LEN + 2);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_ID_LEN + 1);

    typedef enum logic [3:0] {
        IDLE,
        KW,
        KW_WS,
        ID_START,
        ID,
        ID_WS,
`ifdef ARRAY_DECL_EN
        IDX_START,
        IDX,
        IDX_END,
`endif
        ERR
    } state_t;

    function automatic logic is_ws(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h09);
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= "A") && (c <= "Z")) || ((c >= "a") && (c <= "z")) || (c == "_");
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= "0") && (c <= "9");
    endfunction

    // sel=0 spells "int", sel=1 spells "char".
    function automatic logic [7:0] kw_char(input logic sel, input logic [2:0] pos);
        logic [7:0] c;
        case ({sel, pos})
            4'b0000: c = "i";
            4'b0001: c = "n";
            4'b0010: c = "t";
            4'b1000: c = "c";
            4'b1001: c = "h";
            4'b1010: c = "a";
            4'b1011: c = "r";
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] kw_len(input logic sel);
        return sel ? 3'd4 : 3'd3;
    endfunction

    state_t                state, state_n;
    logic                  kw_sel, kw_sel_n;
    logic [2:0]            kw_pos, kw_pos_n;
    logic                  ws_seen, ws_seen_n;
    logic                  err, err_n;
    logic [ID_CNT_W-1:0]   id_cnt, cnt_n;
    logic [LEN_W-1:0]      id_len, len_n;
    logic                  im, im_n;
    logic                  cm, cm_n;
    logic                  done_n, out_n;
    logic [ID_CNT_W-1:0]   id_num_n;
    logic [CNT_W-1:0]      ok_n, errc_n;
    logic                  term, close, bad_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            kw_sel  <= 1'b0;
            kw_pos  <= 3'd0;
            ws_seen <= 1'b0;
            err     <= 1'b0;
            id_cnt  <= '0;
            id_len  <= '0;
            im      <= 1'b0;
            cm      <= 1'b0;
            done    <= 1'b0;
            out     <= 1'b0;
            id_num  <= '0;
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            state   <= state_n;
            kw_sel  <= kw_sel_n;
            kw_pos  <= kw_pos_n;
            ws_seen <= ws_seen_n;
            err     <= err_n;
            id_cnt  <= cnt_n;
            id_len  <= len_n;
            im      <= im_n;
            cm      <= cm_n;
            done    <= done_n;
            out     <= out_n;
            id_num  <= id_num_n;
            ok_cnt  <= ok_n;
            err_cnt <= errc_n;
        end
    end

    always_comb begin
        state_n   = state;
        kw_sel_n  = kw_sel;
        kw_pos_n  = kw_pos;
        ws_seen_n = ws_seen;
        err_n     = err;
        cnt_n     = id_cnt;
        len_n     = id_len;
        im_n      = im;
        cm_n      = cm;
        done_n    = 1'b0;
        out_n     = out;
        id_num_n  = id_num;
        ok_n      = ok_cnt;
        errc_n    = err_cnt;
        term      = 1'b0;
        close     = 1'b0;
        bad_id    = 1'b0;

        if (in_valid) begin
            unique case (state)
                IDLE: begin
                    if ((in == "i") || (in == "c")) begin
                        state_n  = KW;
                        kw_sel_n = (in == "c");
                        kw_pos_n = 3'd1;
                    end else if (!is_ws(in) && (in != ";")) begin
                        state_n = ERR;
                    end
                end
                KW: begin
                    if (in == ";") begin
                        err_n = 1'b1;
                        close = 1'b1;
                    end else if (in == kw_char(kw_sel, kw_pos)) begin
                        kw_pos_n  = kw_pos + 3'd1;
                        ws_seen_n = 1'b0;
                        if (kw_pos_n == kw_len(kw_sel)) state_n = KW_WS;
                    end else begin
                        state_n = ERR;
                    end
                end
                KW_WS, ID_START: begin
                    if (is_ws(in)) begin
                        ws_seen_n = 1'b1;
                    end else if (in == ";") begin
                        err_n = 1'b1;
                        close = 1'b1;
                    end else if (is_letter(in) && (ws_seen || (state == ID_START))) begin
                        state_n = ID;
                        len_n   = LEN_W'(1);
                        im_n    = (in == "i");
                        cm_n    = (in == "c");
                    end else begin
                        state_n = ERR;
                    end
                end
                ID: begin
                    if (is_letter(in) || is_digit(in)) begin
                        if (id_len != LEN_SAT) len_n = id_len + LEN_W'(1);
                        im_n = im && (id_len < LEN_W'(3)) && (in == kw_char(1'b0, 3'(id_len)));
                        cm_n = cm && (id_len < LEN_W'(4)) && (in == kw_char(1'b1, 3'(id_len)));
                    end else if (is_ws(in)) begin
                        term    = 1'b1;
                        state_n = ID_WS;
                    end else if (in == ",") begin
                        term    = 1'b1;
                        state_n = ID_START;
                    end else if (in == ";") begin
                        term  = 1'b1;
                        close = 1'b1;
`ifdef ARRAY_DECL_EN
                    end else if (in == "[") begin
                        term    = 1'b1;
                        state_n = IDX_START;
`endif
                    end else begin
                        state_n = ERR;
                    end
                end
                ID_WS: begin
                    if (in == ",") state_n = ID_START;
                    else if (in == ";") close = 1'b1;
                    else if (!is_ws(in)) state_n = ERR;
                end
`ifdef ARRAY_DECL_EN
                IDX_START: state_n = is_digit(in) ? IDX : ERR;
                IDX: begin
                    if (in == "]") state_n = IDX_END;
                    else if (!is_digit(in)) state_n = ERR;
                end
                IDX_END: begin
                    if (is_ws(in)) state_n = ID_WS;
                    else if (in == ",") state_n = ID_START;
                    else if (in == ";") close = 1'b1;
                    else state_n = ERR;
                end
`endif
                ERR: begin
                    if (in == ";") close = 1'b1;
                end
                default: state_n = ERR;
            endcase

            if (state_n == ERR) err_n = 1'b1;

            // A bad identifier flags the statement but scanning carries on.
            if (term) begin
                bad_id = (id_len > LEN_W'(MAX_ID_LEN)) ||
                         (im && (id_len == LEN_W'(3))) ||
                         (cm && (id_len == LEN_W'(4)));
                if (bad_id) err_n = 1'b1;
                else if (id_cnt != '1) cnt_n = id_cnt + ID_CNT_W'(1);
            end

            if (close) begin
                state_n  = IDLE;
                done_n   = 1'b1;
                out_n    = ~err_n;
                id_num_n = err_n ? '0 : cnt_n;
                if (err_n) begin
                    if (err_cnt != '1) errc_n = err_cnt + CNT_W'(1);
                end else if (ok_cnt != '1) begin
                    ok_n = ok_cnt + CNT_W'(1);
                end
                err_n = 1'b0;
                cnt_n = '0;
            end
        end
    end
endmodule

// File: tb/tb_decl_checker.sv
// Scoreboard bench for decl_checker: expected results queued per statement, checked on done.
module tb_decl_checker;
    localparam int unsigned MAX_ID_LEN = 8;
    localparam int unsigned ID_CNT_W   = 4;
    localparam int unsigned CNT_W      = 2;
    localparam int          SAT        = (1 << CNT_W) - 1;

    logic                clk      = 1'b0;
    logic                reset    = 1'b1;
    logic [7:0]          in       = 8'h00;
    logic                in_valid = 1'b0;
    logic                done;
    logic                out;
    logic [ID_CNT_W-1:0] id_num;
    logic [CNT_W-1:0]    ok_cnt;
    logic [CNT_W-1:0]    err_cnt;

    decl_checker #(
        .MAX_ID_LEN(MAX_ID_LEN),
        .ID_CNT_W  (ID_CNT_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .in_valid(in_valid),
        .done    (done),
        .out     (out),
        .id_num  (id_num),
        .ok_cnt  (ok_cnt),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int out;
        int ids;
        int ok;
        int errc;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   m_ok  = 0;
    int   m_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", int'(done), 0);
            end else begin
                mon_e = sb.pop_front();
                check("done_latency", cyc, mon_e.due);
                check("out", int'(out), mon_e.out);
                check("id_num", int'(id_num), mon_e.ids);
                check("ok_cnt", int'(ok_cnt), mon_e.ok);
                check("err_cnt", int'(err_cnt), mon_e.errc);
            end
        end
    end

    task automatic put(input logic [7:0] b, input logic v);
        in       = b;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    // gap = percent chance of an idle (in_valid=0, random byte) cycle before each byte
    task automatic send(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            while ((gap > 0) && ($urandom_range(99, 0) < gap))
                put(8'($urandom_range(255, 0)), 1'b0);
            put(s[i], 1'b1);
        end
        in_valid = 1'b0;
    endtask

    // s must end in ';'; expected result is queued when that ';' is driven
    task automatic stmt(input string s, input bit good, input int ids, input int gap);
        exp_t e;
        send(s.substr(0, s.len() - 2), gap);
        if (good) m_ok  = (m_ok  < SAT) ? m_ok  + 1 : m_ok;
        else      m_err = (m_err < SAT) ? m_err + 1 : m_err;
        e.out  = good ? 1 : 0;
        e.ids  = good ? ids : 0;
        e.ok   = m_ok;
        e.errc = m_err;
        e.due  = cyc + 1;
        sb.push_back(e);
        put(8'h3B, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        reset = 1'b0;
        m_ok  = 0;
        m_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_done", int'(done), 0);
        check("rst_out", int'(out), 0);
        check("rst_id_num", int'(id_num), 0);
        check("rst_ok_cnt", int'(ok_cnt), 0);
        check("rst_err_cnt", int'(err_cnt), 0);

        // basic legal/illegal statements, back to back
        stmt("int a,b;", 1, 2, 0);
        stmt("char  x1 , _y ;", 1, 2, 0);
        stmt("int int;", 0, 0, 0);
        stmt("int 1a;", 0, 0, 0);
        stmt("intx;", 0, 0, 0);
        send("  ;;", 0);
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        check("empty_ok_cnt", int'(ok_cnt), m_ok);
        check("empty_err_cnt", int'(err_cnt), m_err);
        stmt("x;", 0, 0, 0);

        // identifier length, keyword names, id count saturation, ok_cnt saturation
        do_reset();
        stmt("int abcdefgh;", 1, 1, 0);
        stmt("int abcdefghi;", 0, 0, 0);
        stmt("char\tchar;", 0, 0, 0);
        stmt("int intx;", 1, 1, 0);
        stmt("char charm;", 1, 1, 0);
        stmt("int in;", 1, 1, 0);
        stmt("int a,b,c,d,e,f,g,h,i,j,k,l,m,n,o,p;", 1, 15, 0);
        stmt("int ab-c;", 0, 0, 0);

        // idle gaps mid-statement and early ';' closes
        do_reset();
        stmt("int  foo , bar9;", 1, 2, 40);
        stmt("char;", 0, 0, 40);
        stmt("int a,;", 0, 0, 30);
        stmt("ch;", 0, 0, 30);
        stmt("int a b;", 0, 0, 0);
        stmt("int a ,b,c;", 1, 3, 50);

        // array suffix
`ifdef ARRAY_DECL_EN
        stmt("int a[10],b;", 1, 2, 0);
        stmt("int a[];", 0, 0, 0);
        stmt("int a[1][2];", 0, 0, 0);
        stmt("int abcdefghi[3];", 0, 0, 0);
        stmt("char q[7] ;", 1, 1, 20);
`else
        stmt("int a[10];", 0, 0, 0);
        stmt("char q;", 1, 1, 0);
`endif

        // reset mid-statement drops it
        do_reset();
        send("int a", 0);
        do_reset();
        send(";", 0);
        put(8'h00, 1'b0);
        put(8'h00, 1'b0);
        check("midrst_ok_cnt", int'(ok_cnt), 0);
        check("midrst_err_cnt", int'(err_cnt), 0);
        stmt("int z;", 1, 1, 0);

        repeat (4) put(8'h00, 1'b0);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
